// File: rtl/rca_multiword_ctrl.sv
// Wide add/subtract built from one shared 16-bit ripple slice, one word per clock, LSW first.
// Latency: start accepted at edge T, busy for N_WORDS cycles, done pulses in cycle T+N_WORDS+1.
// Backpressure: start is honoured only in IDLE; requests while busy or in DONE are dropped.

module rca_16bit (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        ci,
    output logic [15:0] s,
    output logic        co
);
    always_comb begin : ripple
        logic cy;
        cy = ci;
        s  = '0;
        for (int i = 0; i < 16; i++) begin
            s[i] = a[i] ^ b[i] ^ cy;
            cy   = (a[i] & b[i]) | (cy & (a[i] ^ b[i]));
        end
        co = cy;
    end
endmodule

module rca_multiword_ctrl #(
    parameter int WORD_W  = 16,
    parameter int N_WORDS = 4,
    parameter int TOTAL_W = WORD_W * N_WORDS
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               sub,
    input  logic [TOTAL_W-1:0] a,
    input  logic [TOTAL_W-1:0] b,
    input  logic               c0,
    output logic               busy,
    output logic               done,
    output logic [TOTAL_W-1:0] s,
    output logic               c
);
    localparam int IDX_W = $clog2(N_WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_WORDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [N_WORDS-1:0][WORD_W-1:0] a_q;
    logic [N_WORDS-1:0][WORD_W-1:0] b_q;
    logic [N_WORDS-1:0][WORD_W-1:0] s_q;
    logic [IDX_W-1:0]               idx;
    logic                           sub_q;
    logic                           carry_q;
    logic                           c_q;

    logic [WORD_W-1:0] slice_a;
    logic [WORD_W-1:0] slice_b;
    logic [WORD_W-1:0] slice_s;
    logic              slice_co;

    // Subtraction is a + ~b + 1; the +1 was loaded into carry_q at accept.
    assign slice_a = a_q[idx];
    assign slice_b = sub_q ? ~b_q[idx] : b_q[idx];

    rca_16bit u_slice (
        .a  (slice_a),
        .b  (slice_b),
        .ci (carry_q),
        .s  (slice_s),
        .co (slice_co)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_RUN;
            ST_RUN:  if (idx == LAST_IDX) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            idx     <= '0;
            sub_q   <= 1'b0;
            carry_q <= 1'b0;
            c_q     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        sub_q   <= sub;
                        carry_q <= sub | c0;
                        idx     <= '0;
                        s_q     <= '0;
                    end
                end
                ST_RUN: begin
                    s_q[idx] <= slice_s;
                    carry_q  <= slice_co;
                    if (idx == LAST_IDX) begin
                        idx <= '0;
                        c_q <= slice_co;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state == ST_RUN);
    assign done = (state == ST_DONE);
    assign s    = s_q;
    assign c    = c_q;

endmodule

// File: doc/rca_multiword_ctrl.md
Name: rca_multiword_ctrl

Overview:
- Sequential controller that time-shares one RCA_16bit slice to add or subtract wide operands of N_WORDS x 16 bits.
- Processes one 16-bit word per clock, least-significant word first.
- Keeps the carry between words in a register.
- Gives the wide datapath a start/busy/done handshake, so the ripple adder is not replicated N_WORDS times.

Parameters:
- WORD_W, 16, width of the shared adder slice; fixed to match RCA_16bit.
- N_WORDS, 4, number of words per operation; legal range 2..16.
- TOTAL_W, WORD_W*N_WORDS, derived operand width; not to be overridden.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on rising edge of clk.
- start  input  1  request pulse; accepted only in IDLE.
- sub  input  1  0 = a+b+c0, 1 = a-b (b inverted, carry-in forced to 1, c0 ignored); latched on accept.
- a  input  TOTAL_W  operand A; latched on accept.
- b  input  TOTAL_W  operand B; latched on accept.
- c0  input  1  carry-in for add mode; latched on accept.
- busy  output  1  high while an operation is in progress (RUN state).
- done  output  1  one-cycle pulse when s/c are final.
- s  output  TOTAL_W  result register.
- c  output  1  final carry-out; in sub mode 1 = no borrow (a >= b unsigned).

Behaviour:
- Reset (rst_n=0 at rising edge): state=IDLE, word index=0, carry reg=0, busy=0, done=0, s=0, c=0, operand registers=0. Reset wins over every other condition, including mid-operation; the aborted result is discarded.
- States and transitions:
  - IDLE -> RUN on start=1.
  - RUN -> RUN while index < N_WORDS-1.
  - RUN -> DONE on the cycle that processes word N_WORDS-1.
  - DONE -> IDLE unconditionally after 1 cycle.
- Accept (IDLE & start): latch a, b, sub, and effective carry-in (sub ? 1 : c0); index=0; clear s to 0.
- RUN, per cycle:
  - Slice inputs: a word[index], b word[index] (bitwise inverted when sub), carry reg.
  - Write slice sum into s word[index] and slice carry-out into carry reg.
  - Increment index.
  - Exactly one slice evaluation per cycle; no combinational path from a/b ports to s.
- DONE: done=1 for exactly this cycle; c = carry reg; busy=0.
- Latency: start accepted at edge T; busy=1 for cycles T+1..T+N_WORDS; done=1 in cycle T+N_WORDS+1.
- Earliest next accept is edge T+N_WORDS+2 (back in IDLE), giving one operation per N_WORDS+2 cycles.
- start while busy or in DONE: ignored, with no effect on in-flight operands.
- Input changes after accept: no effect on the result.
- s and c hold their values from DONE until the next accept. Partial words of s during RUN are not valid to consumers.
- All arithmetic is unsigned modulo 2^TOTAL_W. Carry ripples across word boundaries only through the carry register.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles, release -> busy=0, done=0, s=0, c=0; no state change without start.
- Single-word carry-free case: a=0x0000_0000_0000_02EB, b=0x0000_0000_0000_5555, c0=0, sub=0 -> done in cycle 5 after accept, s=0x0000_0000_0000_5840, c=0.
- Full carry ripple: a=0xFFFF_FFFF_FFFF_FFFF, b=0x1, c0=0 -> s=0, c=1. Check busy is high for exactly 4 cycles.
- Subtract with borrow: a=5, b=7, sub=1, c0=1 (must be ignored) -> s=0xFFFF_FFFF_FFFF_FFFE, c=0. Then a=7, b=5, sub=1 -> s=2, c=1.
- Handshake abuse:
  - Pulse start again on cycle 2 of RUN with different a/b -> ignored; first result is unchanged and there is only one done pulse.
  - Hold start high continuously -> operations accepted every 6 cycles.
- Reset mid-operation: assert rst_n=0 during RUN index 2 -> next cycle busy=0, s=0, c=0, and no done pulse. A new start afterwards produces the correct result.
